// File: rtl/blf_ctrl.sv
// BLF divider controller: measures the TC pulse width, latches the query divide
// ratio and gates the BLF divider for a requested number of doub_blf periods.
module blf_ctrl #(
  parameter int TIMEOUT_CYC = 32,
  parameter int GUARD_CYC   = 12
) (
  input  logic       clk_1_92m,
  input  logic       rst_n,
  input  logic       tc_in,
  input  logic       tc_meas_en,
  input  logic       query_vld,
  input  logic [1:0] dr_in,
  input  logic       tx_req,
  input  logic [7:0] tx_len,
  input  logic       doub_blf,
  output logic [7:0] tc_val,
  output logic [1:0] dr,
  output logic       set_m,
  output logic       div_en,
  output logic       tx_ack,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CFG, RUN, DRAIN} state_t;

  state_t      r_state, w_nxt;
  logic        r_cfg_ok, r_err_lock, r_res_ok, r_blf_d, r_tc_d;
  logic [7:0]  r_tc_cnt, r_len, r_edge_cnt;
  logic [15:0] r_to_cnt, r_grd_cnt;
  logic        w_rise, w_last_edge, w_timeout, w_guard_hit;
  logic        w_grant, w_req_err, w_run_ok, w_run_err, w_fin;
  logic        w_setm_d, w_ack_d, w_done_d, w_err_d, w_div_d, w_busy_d;

  assign w_rise      = doub_blf & ~r_blf_d;
  assign w_last_edge = w_rise && ((r_edge_cnt + 8'd1) == r_len);
  assign w_timeout   = !w_rise && ((r_to_cnt + 16'd1) == 16'(TIMEOUT_CYC));
  assign w_guard_hit = !doub_blf && ((r_grd_cnt + 16'd1) == 16'(GUARD_CYC));

  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // A query always beats a simultaneous tx_req; the request is seen again on return to IDLE.
  always_comb begin
    w_nxt     = r_state;
    w_grant   = 1'b0;
    w_req_err = 1'b0;
    w_run_ok  = 1'b0;
    w_run_err = 1'b0;
    w_fin     = 1'b0;
    case (r_state)
      IDLE: begin
        if (query_vld) begin
          w_nxt = CFG;
        end else if (tx_req && !r_err_lock) begin
          if (r_cfg_ok && (tx_len != 8'd0)) begin
            w_grant = 1'b1;
            w_nxt   = RUN;
          end else begin
            w_req_err = 1'b1;
          end
        end
      end
      CFG: w_nxt = IDLE;
      RUN: begin
        if (!tx_req) begin
          w_run_err = 1'b1;
          w_nxt     = DRAIN;
        end else if (w_last_edge) begin
          w_run_ok = 1'b1;
          w_nxt    = DRAIN;
        end else if (w_timeout) begin
          w_run_err = 1'b1;
          w_nxt     = DRAIN;
        end
      end
      DRAIN: begin
        if (w_guard_hit) begin
          w_fin = 1'b1;
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_setm_d = (r_state == IDLE) && query_vld;
    w_ack_d  = w_grant;
    w_done_d = w_fin && r_res_ok;
    w_err_d  = w_req_err || (w_fin && !r_res_ok);
    w_busy_d = (w_nxt != IDLE);
    w_div_d  = div_en;
    if (w_grant)                 w_div_d = 1'b1;
    else if (w_nxt != RUN)       w_div_d = 1'b0;
  end

  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      set_m   <= 1'b0;
      tx_ack  <= 1'b0;
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      div_en  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      set_m   <= w_setm_d;
      tx_ack  <= w_ack_d;
      tx_done <= w_done_d;
      tx_err  <= w_err_d;
      div_en  <= w_div_d;
      busy    <= w_busy_d;
    end
  end

  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      dr         <= 2'b11;
      r_cfg_ok   <= 1'b0;
      r_err_lock <= 1'b0;
      r_res_ok   <= 1'b0;
      r_len      <= 8'd0;
      r_edge_cnt <= 8'd0;
      r_to_cnt   <= 16'd0;
      r_grd_cnt  <= 16'd0;
      r_blf_d    <= 1'b0;
    end else begin
      r_blf_d <= doub_blf;
      if ((r_state == IDLE) && query_vld) dr <= dr_in;
      if (r_state == CFG) r_cfg_ok <= 1'b1;
      // A refused request stays refused until the encoder drops tx_req.
      if (!tx_req)        r_err_lock <= 1'b0;
      else if (w_req_err) r_err_lock <= 1'b1;
      if (w_run_ok)       r_res_ok <= 1'b1;
      else if (w_run_err) r_res_ok <= 1'b0;
      if (w_grant) r_len <= tx_len;
      if (w_grant)                         r_edge_cnt <= 8'd0;
      else if ((r_state == RUN) && w_rise) r_edge_cnt <= r_edge_cnt + 8'd1;
      if ((r_state != RUN) || w_rise) r_to_cnt <= 16'd0;
      else                            r_to_cnt <= r_to_cnt + 16'd1;
      if ((r_state != DRAIN) || doub_blf) r_grd_cnt <= 16'd0;
      else                                r_grd_cnt <= r_grd_cnt + 16'd1;
    end
  end

  // TC width: only published while idle so the divider setting never shifts mid-reply.
  always_ff @(posedge clk_1_92m or negedge rst_n) begin
    if (!rst_n) begin
      tc_val   <= 8'hFF;
      r_tc_cnt <= 8'd0;
      r_tc_d   <= 1'b0;
    end else begin
      r_tc_d <= tc_in;
      if (!tc_meas_en) begin
        r_tc_cnt <= 8'd0;
      end else if (r_tc_d && !tc_in) begin
        if ((r_tc_cnt != 8'd0) && (r_state == IDLE)) tc_val <= r_tc_cnt;
        r_tc_cnt <= 8'd0;
      end else if (tc_in && (r_tc_cnt != 8'hFF)) begin
        r_tc_cnt <= r_tc_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/blf_ctrl.md
BLF_CTRL -- requirements
Module: blf_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 32: max clk_1_92m cycles between doub_blf rising edges in RUN.
REQ-002 SHALL have parameter GUARD_CYC, default 12: consecutive doub_blf-low cycles required to end DRAIN.
REQ-003 SHALL have port clk_1_92m  in  1  main clock; reset rst_n, asynchronous, active-low.
REQ-004 SHALL have port rst_n  in  1  global reset (asynchronous, active-low).
REQ-005 SHALL have port tc_in  in  1  demodulated TC pulse, already synchronous to clk_1_92m.
REQ-006 SHALL have port tc_meas_en  in  1  enables TC width measurement.
REQ-007 SHALL have port query_vld  in  1  one-cycle pulse, query parsed.
REQ-008 SHALL have port dr_in  in  2  query divide-ratio field, valid with query_vld.
REQ-009 SHALL have port tx_req  in  1  level request from reply encoder for BLF clock.
REQ-010 SHALL have port tx_len  in  8  number of doub_blf periods requested, sampled at grant.
REQ-011 SHALL have port doub_blf  in  1  divider output, sampled on clk_1_92m.
REQ-012 SHALL have outputs tc_val (8), dr (2), set_m (1), div_en (1): divider configuration and enable.
REQ-013 SHALL have outputs tx_ack, tx_done, tx_err (1 each, one-cycle pulses) and busy (1, level).

Function
REQ-014 SHALL implement FSM states IDLE, CFG, RUN, DRAIN; busy = (state != IDLE).
REQ-015 TC measurement: while tc_meas_en=1, 8-bit counter increments each cycle tc_in=1, saturating at 255.
REQ-016 On tc_in 1->0 with count>0: tc_val <= count, counter cleared; update occurs only in IDLE, otherwise tc_val holds and counter clears.
REQ-017 query_vld in IDLE: dr <= dr_in, go CFG; set_m=1 for exactly the CFG cycle (one cycle after query_vld), then IDLE with cfg_ok=1.
REQ-018 query_vld outside IDLE SHALL be ignored (dr, set_m, cfg_ok unchanged).
REQ-019 query_vld and tx_req together in IDLE: query wins; tx_req re-evaluated next IDLE cycle.
REQ-020 tx_req=1 in IDLE with cfg_ok=1 and tx_len!=0: latch tx_len, tx_ack pulse, div_en=1 from the next cycle, go RUN.
REQ-021 tx_req=1 in IDLE with cfg_ok=0 or tx_len=0: tx_err pulse, stay IDLE, div_en stays 0; no repeat until tx_req drops and rises again.
REQ-022 RUN: 8-bit edge counter counts doub_blf 0->1 edges; on the edge making count == latched tx_len, div_en=0 next cycle, go DRAIN, result OK.
REQ-023 RUN: timeout counter clears on each doub_blf rising edge; reaching TIMEOUT_CYC -> div_en=0, DRAIN, result ERR.
REQ-024 RUN: tx_req deasserted -> div_en=0, DRAIN, result ERR.
REQ-025 DRAIN: count consecutive doub_blf=0 cycles (any 1 restarts); at GUARD_CYC -> IDLE with tx_done pulse (OK) or tx_err pulse (ERR).
REQ-026 tx_ack, tx_done, tx_err SHALL be mutually exclusive in any cycle; all outputs registered.
REQ-027 cfg_ok SHALL persist across transfers until reset; each new query re-issues set_m.

Reset
REQ-028 rst_n low, at any state including mid-RUN, SHALL asynchronously force: state IDLE, tc_val=8'hFF, dr=2'b11, set_m=0, div_en=0, tx_ack=0, tx_done=0, tx_err=0, busy=0, cfg_ok=0, all counters 0.

Verification
REQ-029 tc_meas_en=1, tc_in high 20 cycles then low -> tc_val=20; query_vld with dr_in=01 -> dr=01, set_m high exactly one cycle, one cycle after query_vld.
REQ-030 After config, tx_req with tx_len=4, doub_blf model period 6 cycles -> tx_ack; div_en low the cycle after the 4th rising edge; tx_done 12 low cycles later; busy falls with tx_done.
REQ-031 tx_req before any query -> single tx_err pulse, div_en stays 0, busy stays 0.
REQ-032 RUN with doub_blf stuck 0 -> div_en drops 32 cycles after the last edge (or after grant if none); tx_err after 12 guard cycles.
REQ-033 tc_in high 300 cycles -> tc_val=255; TC pulse during RUN -> tc_val unchanged; simultaneous query_vld+tx_req -> set_m first, tx_ack two cycles later.
REQ-034 rst_n asserted mid-RUN -> div_en=0 and busy=0 immediately; a following tx_req gives tx_err (cfg_ok cleared).
